// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge shared types: bridge FSM encoding
// and watchdog counter sizing.
package dmem_bus_bridge_pkg;

   localparam int DMEM_STATE_WIDTH = 2;

   typedef enum logic [DMEM_STATE_WIDTH-1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_REQ  = 2'd1,
      DMEM_RESP = 2'd2,
      DMEM_DONE = 2'd3
   } dmem_state_e;

   // Never narrower than 8 bits; wide enough to reach limit-1.
   function automatic int cnt_width(input int limit);
      if (limit > 256)
         return $clog2(limit);
      return 8;
   endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: clear/enable watchdog counter;
// expired is high while enabled at count LIMIT-1.
module dmem_timeout_cnt #(
   parameter int LIMIT = 255,
   parameter int W     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign expired = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: memory-control request to registered req/gnt/rvalid bus.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_bridge
   import dmem_bus_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  hold_o,
   output logic                  err_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0] bus_wdata_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

   dmem_state_e state;
   logic        start;
   logic        in_flight;
   logic        timeout_fire;

   assign start     = (state == DMEM_IDLE) && req_i;
   assign in_flight = (state == DMEM_REQ) || (state == DMEM_RESP);
   assign hold_o    = start || in_flight;

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

   logic cnt_exp;
   logic err_q;

   dmem_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES),
      .W     (CNT_W)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start),
      .en      (in_flight),
      .expired (cnt_exp)
   );

   // A grant or response in the expiry cycle takes priority.
   assign timeout_fire = cnt_exp &&
      (((state == DMEM_REQ) && !bus_gnt_i) ||
       ((state == DMEM_RESP) && !bus_rvalid_i));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else
         err_q <= timeout_fire;
   end

   assign err_o = err_q;
`else
   assign timeout_fire = 1'b0;
   assign err_o        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= DMEM_IDLE;
         rdata_o     <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
      end else begin
         unique case (state)
            DMEM_IDLE: begin
               if (req_i) begin
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= wr_en_i;
                  bus_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                  bus_wdata_o <= wdata_i;
                  state       <= DMEM_REQ;
               end
            end
            DMEM_REQ: begin
               if (bus_gnt_i) begin
                  bus_req_o <= 1'b0;
                  state     <= DMEM_RESP;
               end else if (timeout_fire) begin
                  bus_req_o <= 1'b0;
                  rdata_o   <= '0;
                  state     <= DMEM_DONE;
               end
            end
            DMEM_RESP: begin
               if (bus_rvalid_i) begin
                  if (!bus_we_o)
                     rdata_o <= bus_rdata_i;
                  state <= DMEM_DONE;
               end else if (timeout_fire) begin
                  rdata_o <= '0;
                  state   <= DMEM_DONE;
               end
            end
            DMEM_DONE: begin
               state <= DMEM_IDLE;
            end
            default: begin
               state <= DMEM_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed bus-handshake sequence
// with a queue of expected completions.
module tb_dmem_bus_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_i = 1'b0;
   logic        wr_en_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        hold_o;
   logic        err_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic        bus_gnt_i = 1'b0;
   logic        bus_rvalid_i = 1'b0;
   logic [31:0] bus_rdata_i = '0;

   typedef struct {
      logic [31:0] rdata;
      int          hold;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_rd = '0;

   dmem_bus_bridge #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .wr_en_i      (wr_en_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .hold_o       (hold_o),
      .err_o        (err_o),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic txn(input bit          we,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input int          gw,
                      input int          rw,
                      input logic [31:0] rd,
                      input bit          chg);
      exp_t        e;
      int          hold;
      logic [31:0] ba;
      @(posedge clk); #1;
      req_i   = 1'b1;
      wr_en_i = we;
      addr_i  = addr;
      wdata_i = wd;
      ba      = {addr[31:2], 2'b00};
      if (!we)
         last_rd = rd;
      e.rdata = last_rd;
      e.hold  = 3 + gw + rw;
      sb.push_back(e);
      hold = 0;
      @(negedge clk);
      if (hold_o) hold++;
      chk("idle_bus_req", 32'(bus_req_o), 32'd0);
      @(posedge clk); #1;
      if (chg) begin
         addr_i  = addr + 32'h10;
         wdata_i = ~wd;
         wr_en_i = ~we;
         req_i   = 1'b0;
      end
      for (int i = 0; i <= gw; i++) begin
         if (i == gw)
            bus_gnt_i = 1'b1;
         @(negedge clk);
         if (hold_o) hold++;
         chk("req_bus_req", 32'(bus_req_o), 32'd1);
         chk("req_addr", bus_addr_o, ba);
         chk("req_we", 32'(bus_we_o), 32'(we));
         chk("req_wdata", bus_wdata_o, wd);
         @(posedge clk); #1;
         bus_gnt_i = 1'b0;
      end
      if (chg)
         req_i = 1'b1;
      for (int i = 0; i <= rw; i++) begin
         if (i == rw) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rd;
         end
         @(negedge clk);
         if (hold_o) hold++;
         chk("resp_bus_req", 32'(bus_req_o), 32'd0);
         @(posedge clk); #1;
         bus_rvalid_i = 1'b0;
         bus_rdata_i  = $urandom;
      end
      @(negedge clk);
      e = sb.pop_front();
      chk("done_hold", 32'(hold_o), 32'd0);
      chk("done_err", 32'(err_o), 32'd0);
      chk("done_rdata", rdata_o, e.rdata);
      chk("hold_cycles", 32'(hold), 32'(e.hold));
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      req_i = 1'b0;
      @(negedge clk);
      chk("idle_hold", 32'(hold_o), 32'd0);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_hold", 32'(hold_o), 32'd0);
      chk("rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("rst_we", 32'(bus_we_o), 32'd0);
      chk("rst_addr", bus_addr_o, 32'd0);
      chk("rst_wdata", bus_wdata_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // zero-wait read
      txn(1'b0, 32'h0000_1004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
      go_idle();

      // write with wait states; rdata_o must keep the last read
      txn(1'b1, 32'h0000_2000, 32'h1234_5678, 3, 1,
          32'hBAD0_BAD0, 1'b0);
      go_idle();

      // read-modify-write pair with req_i held; low bits dropped
      txn(1'b0, 32'h0000_1006, 32'h0, 0, 0, 32'hCAFE_0001, 1'b0);
      txn(1'b1, 32'h0000_1006, 32'hCAFE_0002, 1, 0,
          32'h0F0F_0F0F, 1'b0);
      go_idle();

      // inputs change while waiting for grant
      txn(1'b0, 32'h0000_0010, 32'h0, 2, 0, 32'h55AA_55AA, 1'b1);
      go_idle();

      // reset while waiting for grant drops bus_req_o at once
      @(posedge clk); #1;
      req_i   = 1'b1;
      wr_en_i = 1'b0;
      addr_i  = 32'h0000_3000;
      @(posedge clk); #1;
      chk("pre_rst_bus_req", 32'(bus_req_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_req_bus_req", 32'(bus_req_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // reset during RESP; a stray rvalid afterwards is ignored
      @(posedge clk); #1;
      bus_gnt_i = 1'b1;
      @(posedge clk); #1;
      bus_gnt_i = 1'b0;
      req_i     = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      chk("rst_resp_bus_req", 32'(bus_req_o), 32'd0);
      chk("rst_resp_hold", 32'(hold_o), 32'd0);
      chk("rst_resp_addr", bus_addr_o, 32'd0);
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      bus_rvalid_i = 1'b0;
      @(negedge clk);
      last_rd = 32'h0;
      chk("stray_rvalid_rdata", rdata_o, last_rd);
      chk("stray_rvalid_hold", 32'(hold_o), 32'd0);

      // never grant
      @(posedge clk); #1;
      req_i   = 1'b1;
      wr_en_i = 1'b0;
      addr_i  = 32'h0000_4000;
`ifdef DMEM_TIMEOUT_EN
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("to_wait_err", 32'(err_o), 32'd0);
         chk("to_wait_hold", 32'(hold_o), 32'd1);
      end
      @(posedge clk); #1;
      req_i = 1'b0;
      @(negedge clk);
      chk("to_err_pulse", 32'(err_o), 32'd1);
      chk("to_rdata", rdata_o, 32'd0);
      chk("to_done_hold", 32'(hold_o), 32'd0);
      chk("to_bus_req", 32'(bus_req_o), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_err_once", 32'(err_o), 32'd0);
      chk("to_idle_hold", 32'(hold_o), 32'd0);
`else
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         req_i = 1'b0;
         @(negedge clk);
         chk("nto_hold", 32'(hold_o), 32'd1);
         chk("nto_bus_req", 32'(bus_req_o), 32'd1);
         chk("nto_err", 32'(err_o), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("nto_rst_hold", 32'(hold_o), 32'd0);
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
Sits directly downstream of the result/memory-control stage. Converts its level-style data-memory request (req, wr_en, addr, data) into a registered request/grant/response bus transaction toward data RAM or peripherals. Returns the read word to the memory-control stage and stalls the pipeline through hold_o while a transaction is in flight. One transaction is outstanding at a time; every read or write of the memory-control stage's read-modify-write sequence is a separate transaction.

Parameters:
ADDR_WIDTH, 32, bus address width.
DATA_WIDTH, 32, bus data width (equals `CPU_WIDTH).
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with DMEM_TIMEOUT_EN; must be at least 2.

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
req_i  input  1  memory request from the memory-control stage
wr_en_i  input  1  1 = write, 0 = read
addr_i  input  ADDR_WIDTH  word-aligned byte address
wdata_i  input  DATA_WIDTH  full write word, already merged upstream
rdata_o  output  DATA_WIDTH  registered read data, valid in DONE
hold_o  output  1  pipeline stall request
err_o  output  1  one-cycle timeout pulse (DMEM_TIMEOUT_EN only; else tied 0)
bus_req_o  output  1  bus request
bus_we_o  output  1  bus write enable
bus_addr_o  output  ADDR_WIDTH  bus address, with bits [1:0] forced to 0
bus_wdata_o  output  DATA_WIDTH  bus write data
bus_gnt_i  input  1  bus grant for the current request
bus_rvalid_i  input  1  response valid, used as the ack for both reads and writes
bus_rdata_i  input  DATA_WIDTH  response data

Behaviour:
- Reset: all registers clear asynchronously on rst_n low. State = IDLE. rdata_o, bus_addr_o, bus_wdata_o = 0. bus_req_o, bus_we_o, err_o = 0. Reset mid-transaction drops bus_req_o immediately; the bridge ignores any later rvalid until the next request.
- States: IDLE, REQ, RESP, DONE, in 2-bit encoding.
- IDLE: when req_i = 1, latch addr_i, wr_en_i and wdata_i into the bus_* registers, then go to REQ. When req_i = 0, stay in IDLE.
- REQ: bus_req_o = 1 and the bus_* registers hold stable. When bus_gnt_i = 1, go to RESP and drop bus_req_o on that clock edge. bus_rvalid_i is ignored in REQ; the bus guarantees rvalid comes at least one cycle after gnt.
- RESP: when bus_rvalid_i = 1, register bus_rdata_i into rdata_o (reads only; writes leave rdata_o unchanged) and go to DONE.
- DONE: lasts one cycle, then return to IDLE unconditionally. If req_i is still high in the next IDLE cycle, that is a new transaction.
- hold_o is combinational: (IDLE & req_i) | REQ | RESP. It is 0 in DONE, so the pipeline advances exactly once per transaction.
- Latency: with gnt and rvalid arriving at the earliest legal cycles, hold_o is high for 3 cycles and DONE is on cycle 3. Each extra wait cycle on gnt or rvalid adds one cycle.
- Inputs are sampled only in IDLE. Changes to req_i, addr_i or data inputs during REQ or RESP are ignored.
- rdata_o holds its value until the next read completes.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments in REQ and RESP.
  - When the count equals TIMEOUT_CYCLES-1 with no gnt or rvalid that cycle, drop bus_req_o, set rdata_o = 0, pulse err_o for one cycle, and go to DONE.
  - If gnt or rvalid arrives in the same cycle as the timeout, the normal transition wins.
- Undefined: no counter, the bridge waits indefinitely, and err_o is tied 0.

Decomposition:
- Add to rooth_defines.v: DMEM_STATE_WIDTH (2) and the state encodings DMEM_IDLE, DMEM_REQ, DMEM_RESP, DMEM_DONE.
- One sub-module is natural: dmem_timeout_cnt (clear/enable/expire counter), instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Read, zero wait: req_i=1, wr_en_i=0, addr_i=0x0000_1004; gnt on cycle 1, rvalid on cycle 2 with rdata 0xDEAD_BEEF. Expect bus_addr_o=0x1004, hold_o high for cycles 0-2, rdata_o=0xDEAD_BEEF with hold_o=0 in cycle 3.
- Write with waits: wr_en_i=1, addr_i=0x2000, wdata_i=0x1234_5678; gnt delayed 3 cycles, rvalid delayed 2 more. Expect bus_req_o held with stable we/addr/wdata until gnt, hold_o high for 7 cycles, rdata_o unchanged.
- Back-to-back: req_i held high for a read followed by a write (the RMW pair). Expect two distinct transactions, each separated by one DONE cycle with hold_o=0.
- Reset mid-flight: assert rst_n=0 during RESP. Expect bus_req_o=0, hold_o=0 and state IDLE immediately; a stray rvalid after reset is ignored and rdata_o=0.
- Input change during REQ: change addr_i from 0x10 to 0x20 while waiting for gnt. Expect bus_addr_o to stay 0x10.
- Timeout (DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8): never grant. Expect err_o pulse 8 cycles after entering REQ, rdata_o=0, DONE, then IDLE; with the macro undefined, hold_o stays high.
